serial_audio_stereo_interleaver: RTL and testbench
==================================================

// Module: serial_audio_stereo_interleaver
// PURPOSE
//  Upstream feeder for serial_audio_encoder. Accepts whole stereo frames (left+right in parallel)
//  and buffers them in a small frame FIFO. Emits them as an interleaved word stream (left first,
//  then right) on the encoder's i_valid/i_ready/i_is_left/i_audio handshake, so the producer never
//  has to track channel order.
// PARAMETERS
//  audio_width      32  bits per channel sample
//  fifo_depth_log2  2   log2 of FIFO depth in stereo frames (default 4 frames); must be >= 1
// PORTS
//  clk        in   1            system clock (same clock as the encoder's clk)
//  reset      in   1            asynchronous, active-high reset
//  i_valid    in   1            producer frame valid
//  i_ready    out  1            frame accepted when i_valid && i_ready at posedge clk
//  i_left     in   audio_width  left sample of frame
//  i_right    in   audio_width  right sample of frame
//  o_valid    out  1            word valid toward encoder (to encoder i_valid)
//  o_ready    in   1            encoder ready (from encoder i_ready)
//  o_is_left  out  1            1 = o_audio is left sample (to encoder i_is_left)
//  o_audio    out  audio_width  current word (to encoder i_audio)
//  o_level    out  fifo_depth_log2+1  frames stored; present only with SAI_LEVEL_EN
// BEHAVIOUR
//  - Single clock domain, all state on posedge clk / posedge reset.
//  - Reset: write/read pointers = 0, count = 0, phase = LEFT, storage cleared.
//    i_ready=1 one cycle after reset deasserts, o_valid=0, o_is_left=1, o_audio=0.
//  - Storage: 2**fifo_depth_log2 entries of {left,right}; pointers carry one extra wrap bit;
//    full when pointers differ only in MSB, empty when equal.
//  - Push: i_ready = !full (combinational from registered state). No write-through bypass when full.
//    Push with i_ready low is ignored; the producer must hold i_valid and data.
//  - Pop side: o_valid = !empty. o_audio = head.left when phase=LEFT, head.right when phase=RIGHT;
//    o_audio = 0 when empty. o_is_left = (phase==LEFT).
//  - Latency: a frame pushed into an empty FIFO at edge N gives o_valid=1 (left word) after edge N.
//  - Phase FSM: LEFT --(o_valid&&o_ready)--> RIGHT --(o_valid&&o_ready)--> LEFT + pop head frame.
//    No transition without the handshake; o_audio/o_is_left hold stable while o_valid && !o_ready.
//  - Simultaneous push and pop (right word accepted) in the same cycle: count unchanged, both
//    pointers advance. When full, a pop frees space the NEXT cycle (i_ready rises after the edge).
//  - Pointers wrap modulo 2**(fifo_depth_log2+1); count never exceeds depth or goes below 0.
//  - Left word is never emitted without its right word following; channel order is never swapped.
//  - Reset mid-frame (after left accepted, before right) discards all frames; the next output
//    after reset is the left word of the first newly pushed frame.
// CONFIGURATION
//  - SAI_LEVEL_EN defined: o_level port exists and equals the registered frame count
//    (0..2**fifo_depth_log2). It updates on the same edge as push/pop; reset value is 0.
//  - SAI_LEVEL_EN undefined: the o_level port is absent; all other behaviour is identical.
// TESTING
//  - Reset: assert reset mid-run -> o_valid=0, o_is_left=1, o_audio=0, i_ready=1 after release.
//  - Push {L=AAA7AAA3,R=AAA80AA4}, {L=AAA9AAA5,R=AAAA0AA6}, o_ready=1 -> output words
//    AAA7AAA3(L), AAA80AA4(R), AAA9AAA5(L), AAAA0AA6(R), then o_valid=0.
//  - o_ready=0, push 5 frames with depth 4 -> i_ready=0 after the 4th accept; the 5th is held.
//    Drain -> 8 words in order, 5th frame accepted after the first pop.
//  - Backpressure: o_ready toggling 1/0 every cycle -> o_audio/o_is_left stable whenever
//    o_ready=0; no word dropped or duplicated.
//  - Count=3, push accepted in same cycle as right word accepted -> count stays 3;
//    o_level=3 with SAI_LEVEL_EN.
//  - Loopback: interleaver -> serial_audio_encoder -> serial_audio_decoder, i2s, 32-bit,
//    4 frames -> decoder reports the same 8 words with correct is_left.

Source files
------------

// File: rtl/serial_audio_stereo_interleaver_if.sv
// Handshake bundle between a stereo-frame producer, the interleaver and the
// downstream word consumer (serial_audio_encoder).
interface serial_audio_stereo_interleaver_if #(
    parameter int audio_width = 32
);
    // Both sides use valid/ready: a transfer happens on the rising clk edge where
    // valid && ready; valid never waits for ready, and data holds while valid && !ready.
    logic                   i_valid;
    logic                   i_ready;
    logic [audio_width-1:0] i_left;
    logic [audio_width-1:0] i_right;
    logic                   o_valid;
    logic                   o_ready;
    logic                   o_is_left;
    logic [audio_width-1:0] o_audio;

    modport master (
        output i_valid, i_left, i_right, o_ready,
        input  i_ready, o_valid, o_is_left, o_audio
    );

    modport slave (
        input  i_valid, i_left, i_right, o_ready,
        output i_ready, o_valid, o_is_left, o_audio
    );
endinterface

// File: rtl/serial_audio_stereo_interleaver.sv
// Stereo frame FIFO that replays each frame as a left word then a right word.
// Define SAI_LEVEL_EN to add the o_level frame-count output.
module serial_audio_stereo_interleaver #(
    parameter int audio_width     = 32,
    parameter int fifo_depth_log2 = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    serial_audio_stereo_interleaver_if.slave bus
`ifdef SAI_LEVEL_EN
    ,
    output logic [fifo_depth_log2:0]     o_level
`endif
);
    localparam int AW    = fifo_depth_log2;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {PH_LEFT = 1'b0, PH_RIGHT = 1'b1} phase_e;

    logic [2*audio_width-1:0] mem_q [DEPTH];
    logic [2*audio_width-1:0] mem_d [DEPTH];
    logic [AW:0]              wr_ptr_q, wr_ptr_d;
    logic [AW:0]              rd_ptr_q, rd_ptr_d;
    phase_e                   phase_q, phase_d;

    logic                     full, empty, push, word_xfer, pop_frame;
    logic [2*audio_width-1:0] head;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign push      = bus.i_valid && !full;
    assign word_xfer = !empty && bus.o_ready;
    assign pop_frame = word_xfer && (phase_q == PH_RIGHT);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    assign bus.i_ready   = !full;
    assign bus.o_valid   = !empty;
    assign bus.o_is_left = (phase_q == PH_LEFT);
    assign bus.o_audio   = empty ? '0 :
                           (phase_q == PH_LEFT) ? head[2*audio_width-1:audio_width]
                                                : head[audio_width-1:0];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        phase_d  = phase_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {bus.i_left, bus.i_right};
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (word_xfer) begin
            phase_d = (phase_q == PH_LEFT) ? PH_RIGHT : PH_LEFT;
        end
        if (pop_frame) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

`ifdef SAI_LEVEL_EN
    logic [AW:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop_frame})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    assign o_level = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            phase_q  <= PH_LEFT;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            phase_q  <= phase_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_serial_audio_stereo_interleaver.sv
// Randomized bench for serial_audio_stereo_interleaver: frames accepted by the
// reference model become expected {is_left, word} entries consumed by a monitor.
module tb_serial_audio_stereo_interleaver;
    localparam int W     = 32;
    localparam int LOG2  = 2;
    localparam int DEPTH = 1 << LOG2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   ready_mode;
    int   mon_frames;

    logic [W:0] exp_q[$];

    serial_audio_stereo_interleaver_if #(.audio_width(W)) bus ();

`ifdef SAI_LEVEL_EN
    logic [LOG2:0] o_level;
`endif

    serial_audio_stereo_interleaver #(
        .audio_width    (W),
        .fifo_depth_log2(LOG2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
`ifdef SAI_LEVEL_EN
        ,
        .o_level(o_level)
`endif
    );

    // clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor + reference model: a frame occupies storage until its right word leaves
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            mon_frames = (exp_q.size() + 1) / 2;
            check("i_ready", bus.i_ready, mon_frames < DEPTH);
            check("o_valid", bus.o_valid, exp_q.size() != 0);
`ifdef SAI_LEVEL_EN
            check("o_level", o_level, mon_frames);
`endif
            if (exp_q.size() != 0) begin
                check("o_is_left", bus.o_is_left, exp_q[0][W]);
                check("o_audio", bus.o_audio, exp_q[0][W-1:0]);
                if (bus.o_ready) void'(exp_q.pop_front());
            end else begin
                check("idle_is_left", bus.o_is_left, 1);
                check("idle_audio", bus.o_audio, 0);
            end
            if (bus.i_valid && mon_frames < DEPTH) begin
                exp_q.push_back({1'b1, bus.i_left});
                exp_q.push_back({1'b0, bus.i_right});
            end
        end
    end

    // consumer ready pattern: 0 = held by main sequence, 1 = toggle, 2 = random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       bus.o_ready = ~bus.o_ready;
            2:       bus.o_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // driver tasks: called at posedge+1, return at posedge+1 after the accepting edge
    task automatic push_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        logic acc;
        int   waited;
        bus.i_valid = 1'b1;
        bus.i_left  = l;
        bus.i_right = r;
        acc         = 1'b0;
        waited      = 0;
        while (!acc && waited < 300) begin
            @(negedge clk);
            acc = bus.i_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: frame %0h/%0h not accepted in %0d cycles", l, r, waited);
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic push_rand();
        push_frame($urandom, $urandom);
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        ready_mode  = 0;
        reset       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_left  = '0;
        bus.i_right = '0;
        bus.o_ready = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);

        // two fixed frames with the consumer always ready
        bus.o_ready = 1'b1;
        push_frame(32'hAAA7AAA3, 32'hAAA80AA4);
        push_frame(32'hAAA9AAA5, 32'hAAAA0AA6);
        wait_drain();
        step(2);

        // fill to depth, fifth frame waits for the first pop
        bus.o_ready = 1'b0;
        repeat (DEPTH) push_rand();
        fork
            push_rand();
            begin
                step(4);
                bus.o_ready = 1'b1;
            end
        join
        wait_drain();

        // three stored, push coincides with a right-word pop
        bus.o_ready = 1'b0;
        repeat (3) push_rand();
        bus.o_ready = 1'b1;
        step(1);
        push_rand();
        bus.o_ready = 1'b0;
        step(3);
        bus.o_ready = 1'b1;
        wait_drain();

        // alternating backpressure
        ready_mode = 1;
        repeat (6) push_rand();
        wait_drain();
        ready_mode  = 0;
        bus.o_ready = 1'b0;
        step(1);

        // reset after the left word of a frame has been taken
        repeat (2) push_rand();
        bus.o_ready = 1'b1;
        step(1);
        bus.o_ready = 1'b0;
        reset       = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
        bus.o_ready = 1'b1;
        push_frame(32'h1234_5678, 32'h9ABC_DEF0);
        wait_drain();

        // random traffic and random consumer stalls
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            push_rand();
            step($urandom_range(0, 2));
        end
        wait_drain();
        ready_mode  = 0;
        bus.o_ready = 1'b1;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
